// File: rtl/exe_stage_muldiv_pkg.sv
// cpu_exe_pkg: opcode encodings, mul/div FSM states and decode helpers for exe_stage_muldiv.
package cpu_exe_pkg;
    localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3;
    localparam logic [5:0] OP_XOR = 6'd4, OP_NOR = 6'd5, OP_SLT = 6'd6, OP_SLTU = 6'd7;
    localparam logic [5:0] OP_SLL = 6'd8, OP_SRL = 6'd9, OP_SRA = 6'd10, OP_LUI = 6'd11;
    localparam logic [5:0] OP_ADDU = 6'd12, OP_SUBU = 6'd13;
    localparam logic [5:0] OP_MULT = 6'd16, OP_MULTU = 6'd17, OP_DIV = 6'd18, OP_DIVU = 6'd19;
    localparam logic [5:0] OP_MFHI = 6'd20, OP_MFLO = 6'd21;
    localparam logic [0:0] MD_IDLE = 1'b0, MD_BUSY = 1'b1;
    function automatic logic is_muldiv(input logic [5:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction
endpackage

// File: rtl/exe_stage_muldiv_if.sv
// exe_stage_muldiv_if: ID/EXE inputs and EXE/MEM outputs of the execute stage.
interface exe_stage_muldiv_if #(parameter int WIDTH = 32);
    logic valid_in;
    logic [5:0] aluOpCode_in;
    logic [WIDTH-1:0] aluInputA_in, aluInputB_in, regReadData2_in;
    logic [4:0] regWriteAddress_in;
    logic regShouldWrite_in, memWrite_in, memRead_in, memToReg_in;
    logic stall_out, mdBusy_out, overflow_out;
    logic [WIDTH-1:0] aluResult_out, regReadData2_out;
    logic [4:0] regWriteAddress_out;
    logic regShouldWrite_out, memWrite_out, memRead_out, memToReg_out;
    modport master (
        output valid_in, aluOpCode_in, aluInputA_in, aluInputB_in, regReadData2_in, regWriteAddress_in,
               regShouldWrite_in, memWrite_in, memRead_in, memToReg_in,
        input  stall_out, mdBusy_out, overflow_out, aluResult_out, regReadData2_out, regWriteAddress_out,
               regShouldWrite_out, memWrite_out, memRead_out, memToReg_out
    );
    modport slave (
        input  valid_in, aluOpCode_in, aluInputA_in, aluInputB_in, regReadData2_in, regWriteAddress_in,
               regShouldWrite_in, memWrite_in, memRead_in, memToReg_in,
        output stall_out, mdBusy_out, overflow_out, aluResult_out, regReadData2_out, regWriteAddress_out,
               regShouldWrite_out, memWrite_out, memRead_out, memToReg_out
    );
endinterface

// File: rtl/exe_stage_muldiv_md_unit.sv
// md_unit: iterative shift-add multiplier / restoring divider owning HI and LO.
module md_unit import cpu_exe_pkg::*; #(parameter int WIDTH = 32, parameter int MD_STEPS = 32) (
    input  logic CLK,
    input  logic rst,
    input  logic start,
    input  logic [5:0] op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(MD_STEPS);
    localparam logic [CW-1:0] LAST = CW'(MD_STEPS - 1);
    logic [0:0] state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] r, q, mb, r_n, q_n, ma, mbm, quo, rem;
    logic [WIDTH:0] t, sh, d;
    logic [2*WIDTH-1:0] prod;
    logic sgn, div_op, ge, is_div, neg_main, neg_rem;
    // r:q is the product accumulator for multiply, remainder:dividend for divide
    always_comb begin
        sgn = op == OP_MULT || op == OP_DIV;
        div_op = op == OP_DIV || op == OP_DIVU;
        ma = sgn && a[WIDTH-1] ? -a : a;
        mbm = sgn && b[WIDTH-1] ? -b : b;
        t = {1'b0, r} + {1'b0, q[0] ? mb : {WIDTH{1'b0}}};
        sh = {r, q[WIDTH-1]};
        d = sh - {1'b0, mb};
        ge = sh >= {1'b0, mb};
        r_n = is_div ? (ge ? d[WIDTH-1:0] : sh[WIDTH-1:0]) : t[WIDTH:1];
        q_n = is_div ? {q[WIDTH-2:0], ge} : {t[0], q[WIDTH-1:1]};
        prod = neg_main ? -{r_n, q_n} : {r_n, q_n};
        quo = neg_main ? -q_n : q_n;
        rem = neg_rem ? -r_n : r_n;
    end
    assign busy = state == MD_BUSY;
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt <= '0;
            hi <= '0;
            lo <= '0;
            r <= '0;
            q <= '0;
            mb <= '0;
            is_div <= 1'b0;
            neg_main <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == MD_IDLE) begin
            if (start && div_op && b == '0) begin
                hi <= a;
                lo <= '1;
            end else if (start) begin
                state <= MD_BUSY;
                cnt <= '0;
                r <= '0;
                q <= ma;
                mb <= mbm;
                is_div <= div_op;
                neg_main <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem <= sgn && a[WIDTH-1];
            end
        end else begin
            r <= r_n;
            q <= q_n;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state <= MD_IDLE;
                {hi, lo} <= is_div ? {rem, quo} : prod;
            end
        end
    end
endmodule

// File: rtl/exe_stage_muldiv.sv
// exe_stage_muldiv: execute stage with single-cycle ALU and iterative HI/LO mul/div unit.
// Optional signed-overflow trap on ADD/SUB under macro OVERFLOW_TRAP_EN.
module exe_stage_muldiv import cpu_exe_pkg::*; #(parameter int WIDTH = 32, parameter int MD_STEPS = 32) (
    input logic CLK,
    input logic Reset_in,
    exe_stage_muldiv_if.slave bus
);
    logic [5:0] op;
    logic [WIDTH-1:0] a, b, hi, lo, res, sum, diff;
    logic [4:0] sa;
    logic md, stall, load, ovf;
    assign op = bus.aluOpCode_in;
    assign a = bus.aluInputA_in;
    assign b = bus.aluInputB_in;
    assign sa = b[5:1];
    assign sum = a + b;
    assign diff = a - b;
    assign md = is_muldiv(op);
    assign stall = bus.valid_in && bus.mdBusy_out && (md || op == OP_MFHI || op == OP_MFLO);
    assign load = bus.valid_in && !stall;
    assign bus.stall_out = stall;
    md_unit #(.WIDTH(WIDTH), .MD_STEPS(MD_STEPS)) u_md (
        .CLK(CLK), .rst(Reset_in), .start(load && md), .op(op), .a(a), .b(b),
        .busy(bus.mdBusy_out), .hi(hi), .lo(lo)
    );
`ifdef OVERFLOW_TRAP_EN
    assign ovf = (op == OP_ADD && a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) ||
                 (op == OP_SUB && a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1]);
`else
    assign ovf = 1'b0;
`endif
    always_comb begin
        res = '0;
        case (op)
            OP_ADD, OP_ADDU: res = sum;
            OP_SUB, OP_SUBU: res = diff;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  res = b << sa;
            OP_SRL:  res = b >> sa;
            OP_SRA:  res = $signed(b) >>> sa;
            OP_LUI:  res = {b[16:1], 16'h0};
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            default: res = '0;
        endcase
    end
    // stalls and empty slots become bubbles: write enables drop, payload holds
    always_ff @(posedge CLK) begin
        if (Reset_in) begin
            bus.aluResult_out <= '0;
            bus.regReadData2_out <= '0;
            bus.regWriteAddress_out <= '0;
            bus.regShouldWrite_out <= 1'b0;
            bus.memWrite_out <= 1'b0;
            bus.memRead_out <= 1'b0;
            bus.memToReg_out <= 1'b0;
            bus.overflow_out <= 1'b0;
        end else begin
            bus.regShouldWrite_out <= load && !md && bus.regShouldWrite_in && !ovf;
            bus.memWrite_out <= load && bus.memWrite_in;
            bus.memRead_out <= load && bus.memRead_in;
            bus.overflow_out <= load && ovf;
            if (load) begin
                bus.aluResult_out <= res;
                bus.regReadData2_out <= bus.regReadData2_in;
                bus.regWriteAddress_out <= bus.regWriteAddress_in;
                bus.memToReg_out <= bus.memToReg_in;
            end
        end
    end
endmodule

// File: tb/tb_exe_stage_muldiv.sv
// tb_exe_stage_muldiv: randomized bench with a behavioural execute-stage model and directed literal checks.
module tb_exe_stage_muldiv;
    import cpu_exe_pkg::*;
`ifdef OVERFLOW_TRAP_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    logic CLK = 1'b0;
    logic Reset_in = 1'b1;
    always #5 CLK = ~CLK;
    exe_stage_muldiv_if bus();
    exe_stage_muldiv dut (.CLK(CLK), .Reset_in(Reset_in), .bus(bus));

    int checks = 0, failures = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int rem = 0;
    logic [31:0] e_res = 0, e_d2 = 0;
    logic [4:0] e_wa = 0;
    logic e_rsw = 0, e_mw = 0, e_mr = 0, e_mtr = 0, e_ovf = 0, res_known = 1, last_st = 0;
    logic [5:0] ops [20] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL,
                             OP_SRA, OP_LUI, OP_ADDU, OP_SUBU, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s = b[5:1];
        case (op)
            OP_ADD, OP_ADDU: return a + b;
            OP_SUB, OP_SUBU: return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'b0, a < b};
            OP_SLL:  return b << s;
            OP_SRL:  return b >> s;
            OP_SRA:  return 32'($signed(b) >>> s);
            OP_LUI:  return {b[16:1], 16'h0};
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ovf_of(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = op == OP_ADD ? longint'($signed(a)) + longint'($signed(b)) : longint'($signed(a)) - longint'($signed(b));
        return (op == OP_ADD || op == OP_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
    endfunction

    task automatic set(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_in = v;
        bus.aluOpCode_in = op;
        bus.aluInputA_in = a;
        bus.aluInputB_in = b;
        bus.regShouldWrite_in = 1'b1;
        bus.memWrite_in = 1'($urandom);
        bus.memRead_in = 1'($urandom);
        bus.memToReg_in = 1'($urandom);
        bus.regWriteAddress_in = 5'($urandom);
        bus.regReadData2_in = $urandom;
    endtask

    task automatic step(input logic r);
        logic [5:0] op;
        logic [31:0] a, b, res;
        logic md, ld, ov;
        longint sq, sr;
        logic [63:0] pr;
        Reset_in = r;
        #1;
        op = bus.aluOpCode_in;
        a = bus.aluInputA_in;
        b = bus.aluInputB_in;
        md = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        last_st = bus.valid_in && rem > 0 && (md || op == OP_MFHI || op == OP_MFLO);
        chk("stall_out", bus.stall_out, last_st);
        ld = bus.valid_in && !last_st;
        res = ref_alu(op, a, b);
        ov = OVF && ovf_of(op, a, b);
        if (r) begin
            {e_res, e_d2, e_wa, e_rsw, e_mw, e_mr, e_mtr, e_ovf} = '0;
            res_known = 1'b1;
            rem = 0;
            m_hi = 0;
            m_lo = 0;
        end else begin
            e_rsw = ld && !md && bus.regShouldWrite_in && !ov;
            e_mw = ld && bus.memWrite_in;
            e_mr = ld && bus.memRead_in;
            e_ovf = ld && ov;
            if (ld) begin
                e_res = res;
                res_known = !md;
                e_d2 = bus.regReadData2_in;
                e_wa = bus.regWriteAddress_in;
                e_mtr = bus.memToReg_in;
            end
            if (rem > 0) begin
                rem--;
                if (rem == 0) {m_hi, m_lo} = {p_hi, p_lo};
            end
            if (ld && md) begin
                if ((op == OP_DIV || op == OP_DIVU) && b == 0) begin
                    m_hi = a;
                    m_lo = '1;
                end else begin
                    case (op)
                        OP_MULT:  pr = 64'(longint'($signed(a)) * longint'($signed(b)));
                        OP_MULTU: pr = {32'b0, a} * {32'b0, b};
                        OP_DIV: begin
                            sq = longint'($signed(a)) / longint'($signed(b));
                            sr = longint'($signed(a)) % longint'($signed(b));
                            pr = {sr[31:0], sq[31:0]};
                        end
                        default:  pr = {a % b, a / b};
                    endcase
                    {p_hi, p_lo} = pr;
                    rem = 32;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        if (res_known) chk("aluResult_out", bus.aluResult_out, e_res);
        chk("regShouldWrite_out", bus.regShouldWrite_out, e_rsw);
        chk("memWrite_out", bus.memWrite_out, e_mw);
        chk("memRead_out", bus.memRead_out, e_mr);
        chk("memToReg_out", bus.memToReg_out, e_mtr);
        chk("regWriteAddress_out", bus.regWriteAddress_out, e_wa);
        chk("regReadData2_out", bus.regReadData2_out, e_d2);
        chk("overflow_out", bus.overflow_out, e_ovf);
        chk("mdBusy_out", bus.mdBusy_out, rem > 0);
        chk("hi", dut.u_md.hi, m_hi);
        chk("lo", dut.u_md.lo, m_lo);
    endtask

    initial begin
        int n;
        set(0, OP_ADD, 0, 0);
        @(negedge CLK);
        step(1);
        step(1);
        chk("rst_result", bus.aluResult_out, 0);
        chk("rst_busy", bus.mdBusy_out, 0);
        set(1, OP_ADD, 7, 5);
        step(0);
        chk("add_lit", bus.aluResult_out, 32'd12);
        chk("add_rsw_lit", bus.regShouldWrite_out, 1);
        set(1, OP_SRA, 0, 32'h80000000);
        step(0);
        chk("sra_lit", bus.aluResult_out, 32'h80000000);
        set(1, OP_MULT, 32'hFFFFFFFD, 4);
        step(0);
        set(0, OP_ADD, 0, 0);
        n = 0;
        for (int i = 0; i < 40 && bus.mdBusy_out; i++) begin
            step(0);
            n++;
        end
        chk("mult_busy_cycles", n, 32);
        chk("mult_hi_lit", dut.u_md.hi, 32'hFFFFFFFF);
        chk("mult_lo_lit", dut.u_md.lo, 32'hFFFFFFF4);
        set(1, OP_DIV, 32'hFFFFFFF9, 2);
        step(0);
        set(1, OP_MFLO, 0, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(0);
            if (!last_st) break;
            n++;
            chk("stall_bubble_lit", bus.regShouldWrite_out, 0);
        end
        chk("div_stall_cycles", n, 32);
        chk("mflo_lit", bus.aluResult_out, 32'hFFFFFFFD);
        set(1, OP_MFHI, 0, 0);
        step(0);
        chk("mfhi_lit", bus.aluResult_out, 32'hFFFFFFFF);
        set(1, OP_DIVU, 9, 0);
        step(0);
        chk("div0_busy_lit", bus.mdBusy_out, 0);
        set(1, OP_MFLO, 0, 0);
        step(0);
        chk("div0_lo_lit", bus.aluResult_out, 32'hFFFFFFFF);
        set(1, OP_MFHI, 0, 0);
        step(0);
        chk("div0_hi_lit", bus.aluResult_out, 32'd9);
        set(1, OP_MULTU, $urandom, $urandom);
        step(0);
        set(0, OP_ADD, 0, 0);
        repeat (10) step(0);
        step(1);
        chk("rst_mid_busy_lit", bus.mdBusy_out, 0);
        chk("rst_mid_hi_lit", dut.u_md.hi, 0);
        chk("rst_mid_res_lit", bus.aluResult_out, 0);
`ifdef OVERFLOW_TRAP_EN
        set(1, OP_ADD, 32'h7FFFFFFF, 1);
        step(0);
        chk("ovf_flag_lit", bus.overflow_out, 1);
        chk("ovf_rsw_lit", bus.regShouldWrite_out, 0);
        set(1, OP_ADDU, 32'h7FFFFFFF, 1);
        step(0);
        chk("addu_res_lit", bus.aluResult_out, 32'h80000000);
        chk("addu_flag_lit", bus.overflow_out, 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            if (!last_st) begin
                logic [5:0] op;
                logic [31:0] a, b;
                op = ops[$urandom_range(19)];
                a = ($urandom % 4 == 0) ? 32'($urandom_range(20)) - 32'd10 : $urandom;
                b = ($urandom % 4 == 0) ? 32'($urandom_range(20)) - 32'd10 : $urandom;
                if ($urandom % 10 == 0) b = 0;
                if ($urandom % 10 == 0) a = 32'h80000000;
                set($urandom % 8 != 0, op, a, b);
                bus.regShouldWrite_in = 1'($urandom);
            end
            step($urandom % 400 == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exe_stage_muldiv.md
Name: exe_stage_muldiv

Overview:
- Execute stage that sits directly downstream of the ID/EXE pipeline register and feeds the EXE/MEM boundary.
- Single-cycle ALU ops produce a registered result one cycle after issue.
- MULT/MULTU/DIV/DIVU run on an iterative 32-step unit that writes the HI/LO registers.
- Younger instructions that read HI/LO or start another mul/div stall while the unit is busy. All other ops keep flowing.

Parameters:
- WIDTH, 32, datapath width.
- MD_STEPS, 32, mul/div iterations; must equal WIDTH.

Ports:
- CLK  in  1  clock, all state changes on rising edge
- Reset_in  in  1  synchronous, active-high reset
- valid_in  in  1  ID/EXE holds a real instruction (0 = bubble)
- aluOpCode_in  in  6  operation, encodings from package
- aluInputA_in  in  32  operand A (rs data)
- aluInputB_in  in  32  operand B (rt data or immediate, already muxed)
- regShouldWrite_in, memWrite_in, memRead_in, memToReg_in  in  1 each  control passthrough
- regWriteAddress_in  in  5  destination register
- regReadData2_in  in  32  store data passthrough
- stall_out  out  1  combinational; upstream holds PC, IF/ID and ID/EXE while high
- mdBusy_out  out  1  mul/div unit iterating
- aluResult_out  out  32  registered result
- regReadData2_out  out  32  registered store data
- regWriteAddress_out  out  5  registered
- regShouldWrite_out, memWrite_out, memRead_out, memToReg_out  out  1 each  registered
- overflow_out  out  1  registered; only with OVERFLOW_TRAP_EN, otherwise tied 0

Behaviour:
- Reset, sampled at the edge: all outputs 0, HI=LO=0, FSM IDLE, step counter 0. Reset aborts any mul/div in flight; HI/LO are not updated.
- Single-cycle ops:
  - ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI.
  - Shift amount is B[5:1]. LUI result is {B[16:1],16'h0}.
  - ADD/SUB wrap modulo 2^32.
  - Result registered at the next edge (latency 1).
- MFHI/MFLO: result is HI/LO, latency 1.
- MULT-class ops (MULT, MULTU, DIV, DIVU) produce no register write.
- FSM states: IDLE, BUSY.
  - IDLE→BUSY at the edge where a mul/div is accepted: operands latched, counter=0.
  - BUSY: one shift-add or restoring-subtract step per edge, counter+1.
  - At the edge where counter reaches MD_STEPS-1: HI/LO are written and the FSM returns to IDLE.
  - Accept at edge N → HI/LO valid after edge N+32. mdBusy_out is high between those edges.
- Signed ops: operate on magnitudes, then fix signs.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend sign.
  - MULT/MULTU: HI:LO = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: no iteration, stays IDLE. LO=32'hFFFFFFFF and HI=A at the next edge.
- stall_out = valid_in & mdBusy_out & op ∈ {MFHI, MFLO, MULT-class}.
- While stalled, the output register loads a bubble:
  - regShouldWrite_out, memWrite_out and memRead_out are 0.
  - The other outputs hold their previous values.
- Same-cycle completion: an MFHI presented in the cycle that ends with the completing edge is still stalled. It issues in the next cycle and reads the new HI.
- valid_in=0: the output register loads a bubble, as above.

Optional Feature:
- Macro OVERFLOW_TRAP_EN.
- Defined: signed overflow on ADD or SUB sets overflow_out=1 for that cycle and forces regShouldWrite_out=0.
  - Overflow means operands of equal sign with a result of the opposite sign (for SUB, compare against the negated B).
  - A separate ADDU/SUBU opcode never flags overflow.
- Undefined: overflow_out is constant 0, and ADD behaves like ADDU.

Decomposition:
- Package cpu_exe_pkg holds:
  - the 6-bit opcode localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11, ADDU=12, SUBU=13, MULT=16, MULTU=17, DIV=18, DIVU=19, MFHI=20, MFLO=21;
  - the FSM state encoding;
  - a function is_muldiv(op).
- One sub-module, md_unit: the iterative multiplier/divider with its FSM, counter and HI/LO. It exposes start, op, a, b, busy, hi, lo.

Test Plan:
- ADD A=7, B=5, valid → next edge aluResult_out=12, regShouldWrite_out=1; SRA A=0, B=32'h80000000 with B[5:1]=0 → shifted result equals B.
- MULT A=-3 (32'hFFFFFFFD), B=4 → mdBusy_out high for 32 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFF4.
- DIV A=-7, B=2, then MFLO issued one cycle later → stall_out high until completion, bubble outputs meanwhile; MFLO result=32'hFFFFFFFD (-3); a following MFHI returns 32'hFFFFFFFF (-1).
- DIVU A=9, B=0 → mdBusy_out never rises; LO=32'hFFFFFFFF, HI=9.
- Reset asserted mid-MULTU (cycle 10 of 32) → next edge: mdBusy_out=0, HI=LO=0, all outputs 0.
- With OVERFLOW_TRAP_EN: ADD 32'h7FFFFFFF+1 → overflow_out=1, regShouldWrite_out=0; ADDU of the same operands → result 32'h80000000, no flag.
